// File: rtl/md_unit_pkg.sv
// Shared MD operation codes and a small decode helper for the multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  function automatic logic md_is_multi(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV with a busy countdown,
// single-cycle MTHI/MTLO, and combinational MFHI/MFLO reads of HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_pend;
  logic          r_pend_wr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic          w_is_multi;
  logic          w_is_div;
  logic          w_signed_div;
  logic          w_div_zero;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;
  logic [63:0]   w_result;
  logic [31:0]   w_md_out;

  assign w_is_multi   = md_is_multi(md_op);
  assign w_is_div     = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign w_signed_div = (md_op == MD_DIV);
  assign w_div_zero   = (rt_data == '0);

  // Signed divide via magnitudes: avoids simulator quirks on -2^31 / -1 and
  // gives truncation toward zero with the remainder carrying the dividend sign.
  assign w_a_mag = (w_signed_div && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign w_b_mag = w_div_zero ? 32'd1 :
                   ((w_signed_div && rt_data[31]) ? (32'd0 - rt_data) : rt_data);
  assign w_uq    = w_a_mag / w_b_mag;
  assign w_ur    = w_a_mag % w_b_mag;
  assign w_quot  = (w_signed_div && (rs_data[31] ^ rt_data[31])) ? (32'd0 - w_uq) : w_uq;
  assign w_rem   = (w_signed_div && rs_data[31]) ? (32'd0 - w_ur) : w_ur;

  always_comb begin
    w_result = '0;
    case (md_op)
      MD_MULT:  w_result = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
      MD_MULTU: w_result = {32'd0, rs_data} * {32'd0, rt_data};
      MD_DIV,
      MD_DIVU:  w_result = {w_rem, w_quot};
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        if (r_pend_wr) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (start && w_is_multi) begin
      r_busy    <= 1'b1;
      r_cnt     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      r_pend    <= w_result;
      r_pend_wr <= !(w_is_div && w_div_zero);
    end else if (md_op == MD_MTHI) begin
      r_hi <= rs_data;
    end else if (md_op == MD_MTLO) begin
      r_lo <= rs_data;
    end
  end

  always_comb begin
    w_md_out = '0;
    case (md_op)
      MD_MFHI: w_md_out = r_hi;
      MD_MFLO: w_md_out = r_lo;
      default: w_md_out = '0;
    endcase
  end

  assign busy   = r_busy;
  assign md_out = w_md_out;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, arithmetic, divide-by-zero,
// reset abort and ignored requests while busy.
module tb_md_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] md_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .md_out  (md_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    md_op   = op;
    start   = st;
    rs_data = a;
    rt_data = b;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    md_op = OP_MFHI;
    #1 hi = md_out;
    md_op = OP_MFLO;
    #1 lo = md_out;
    md_op = OP_NONE;
  endtask

  // Starts an op and counts cycles with busy high (bounded at 50).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
    drive(op, 1'b1, a, b);
    step();
    drive(OP_NONE, 1'b0, '0, '0);
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1;
    drive(OP_NONE, 1'b0, '0, '0);
    step();
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000002, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_multu();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=5", cyc); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    read_hilo(hi, lo);
    total++; if (hi !== 32'h00000000) begin bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end

    run_op(OP_DIVU, 32'h00000007, 32'h00000002, cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    total++; if (lo !== 32'h00000003) begin bad++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
  endtask

  task automatic test_md_none();
    md_op = OP_NONE;
    #1;
    total++; if (md_out !== 32'h0) begin bad++; $display("FAIL none_out got=%h exp=00000000", md_out); end
    md_op = OP_MTHI;
    #1;
    total++; if (md_out !== 32'h0) begin bad++; $display("FAIL mthi_out got=%h exp=00000000", md_out); end
    md_op = OP_NONE;
  endtask

  task automatic test_divzero();
    logic [31:0] hi, lo;
    int cyc;
    drive(OP_MTHI, 1'b0, 32'h12345678, '0);
    step();
    drive(OP_NONE, 1'b0, '0, '0);
    run_op(OP_DIVU, 32'h00000007, 32'h00000000, cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL divz_busy_cycles got=%0d exp=10", cyc); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL divz_hi got=%h exp=12345678", hi); end
    total++; if (lo !== 32'h00000003) begin bad++; $display("FAIL divz_lo got=%h exp=00000003", lo); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    drive(OP_MULT, 1'b1, 32'h00010000, 32'h00010000);
    step();
    drive(OP_NONE, 1'b0, '0, '0);
    step();
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%0b exp=1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%0b exp=0", busy); end
    read_hilo(hi, lo);
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h exp=00000000", lo); end
    for (int i = 0; i < 8; i++) step();
    read_hilo(hi, lo);
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL abort_late_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL abort_late_lo got=%h exp=00000000", lo); end
  endtask

  task automatic test_back_to_back();
    drive(OP_MTHI, 1'b0, 32'h11111111, '0);
    step();
    drive(OP_MTLO, 1'b0, 32'h0BADF00D, '0);
    step();
    drive(OP_DIV, 1'b1, 32'd100, 32'd7);
    step();
    for (int c = 1; c < 10; c++) begin
      case (c)
        2:       drive(OP_MULT, 1'b1, 32'd3, 32'd3);
        4:       drive(OP_MTLO, 1'b0, 32'h0000DEAD, '0);
        default: drive(OP_NONE, 1'b0, '0, '0);
      endcase
      step();
    end
    drive(OP_MFLO, 1'b0, '0, '0);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_last got=%0b exp=1", busy); end
    total++; if (md_out !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_old_lo got=%h exp=0badf00d", md_out); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_done got=%0b exp=0", busy); end
    total++; if (md_out !== 32'd14) begin bad++; $display("FAIL b2b_new_lo got=%h exp=0000000e", md_out); end
    md_op = OP_MFHI;
    #1;
    total++; if (md_out !== 32'd2) begin bad++; $display("FAIL b2b_new_hi got=%h exp=00000002", md_out); end
    md_op = OP_NONE;
  endtask

  initial begin
    reset = 1'b1;
    drive(OP_NONE, 1'b0, '0, '0);
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_md_none();
    test_divzero();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
